// File: rtl/audio_i2s_out.sv
// I2S audio transmitter for two square-wave tone channels. Clocks are taken
// from a free-running 9-bit divider, and one 32-bit frame is loaded every 512 clks.
module audio_i2s_out #(
  parameter int unsigned SILENT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] freqL,
  input  logic [25:0] freqR,
  input  logic [2:0]  volume,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        frame_stb
);

  localparam logic [25:0] SILENT_Q = 26'(SILENT_DIV);

  logic [8:0]       cnt_q, cnt_d;
  logic [1:0][25:0] per_q, per_d;
  logic [1:0]       sq_q, sq_d;
  logic [31:0]      frame_q, frame_d;
  logic             rprev_q, rprev_d;
  logic             sdin_q, sdin_d;
  logic             stb_q, stb_d;

  logic [1:0][25:0] freq_s;
  logic [1:0]       silent_s;
  logic [1:0][15:0] samp_s;
  logic [15:0]      amp_s;
  logic             frame_load_s;
  logic [4:0]       slot_nxt_s;

  function automatic logic [15:0] amp_of(input logic [2:0] vol);
    logic [15:0] a;
    case (vol)
      3'd0:    a = 16'h0000;
      3'd1:    a = 16'h0400;
      3'd2:    a = 16'h1000;
      3'd3:    a = 16'h2000;
      default: a = 16'h4000;
    endcase
    return a;
  endfunction

  function automatic logic [15:0] sample_of(input logic silent, input logic sq,
                                            input logic [15:0] amp);
    logic [15:0] s;
    if (silent) begin
      s = 16'h0000;
    end else if (sq) begin
      s = amp;
    end else begin
      s = 16'h0000 - amp;
    end
    return s;
  endfunction

  assign freq_s       = {freqR, freqL};
  assign amp_s        = amp_of(volume);
  assign frame_load_s = (cnt_q == 9'd511);
  assign slot_nxt_s   = cnt_q[8:4] + 5'd1;

  // Per-channel tone generators; the live freq is compared every cycle so a
  // change takes effect mid-period.
  always_comb begin
    per_d = per_q;
    sq_d  = sq_q;
    for (int ch = 0; ch < 2; ch++) begin
      silent_s[ch] = (freq_s[ch] <= SILENT_Q);
      if (silent_s[ch]) begin
        per_d[ch] = 26'd0;
        sq_d[ch]  = 1'b0;
      end else if (per_q[ch] >= freq_s[ch] - 26'd1) begin
        per_d[ch] = 26'd0;
        sq_d[ch]  = ~sq_q[ch];
      end else begin
        per_d[ch] = per_q[ch] + 26'd1;
      end
      samp_s[ch] = sample_of(silent_s[ch], sq_q[ch], amp_s);
    end
  end

  // Frame load and serializer; bit 31 of the new frame leaves on the load edge.
  always_comb begin
    cnt_d   = cnt_q + 9'd1;
    frame_d = frame_q;
    rprev_d = rprev_q;
    sdin_d  = sdin_q;
    stb_d   = frame_load_s;
    if (frame_load_s) begin
      frame_d = {rprev_q, samp_s[0], samp_s[1][15:1]};
      rprev_d = samp_s[1][0];
      sdin_d  = rprev_q;
    end else if (cnt_q[3:0] == 4'hF) begin
      sdin_d = frame_q[5'd31 - slot_nxt_s];
    end else begin
      sdin_d = sdin_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 9'd0;
      per_q   <= '0;
      sq_q    <= 2'b00;
      frame_q <= 32'd0;
      rprev_q <= 1'b0;
      sdin_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      sq_q    <= sq_d;
      frame_q <= frame_d;
      rprev_q <= rprev_d;
      sdin_q  <= sdin_d;
      stb_q   <= stb_d;
    end
  end

  assign audio_mclk = cnt_q[1];
  assign audio_sck  = cnt_q[3];
  assign audio_lrck = cnt_q[8];
  assign audio_sdin = sdin_q;
  assign frame_stb  = stb_q;

endmodule

// File: tb/tb_audio_i2s_out.sv
// Bench for audio_i2s_out: table of first-frame vectors, directed corner
// sequences, and randomized runs checked every cycle against a frame-level model.
module tb_audio_i2s_out;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [25:0] freqL = 26'd0;
  logic [25:0] freqR = 26'd0;
  logic [2:0]  volume = 3'd0;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_stb;

  int total = 0;
  int bad   = 0;

  audio_i2s_out #(.SILENT_DIV(1)) dut (
    .clk(clk), .rst(rst), .freqL(freqL), .freqR(freqR), .volume(volume),
    .audio_mclk(audio_mclk), .audio_lrck(audio_lrck), .audio_sck(audio_sck),
    .audio_sdin(audio_sdin), .frame_stb(frame_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time since reset release, per-channel elapsed count and
  // square level, and the frame last loaded.
  int          m_t, m_el_l, m_el_r;
  logic        m_sq_l, m_sq_r, m_rprev, m_stb;
  logic [31:0] m_frame;
  logic [15:0] m_sl, m_sr;

  function automatic logic [15:0] mdl_sample(input logic [25:0] f, input logic [2:0] v,
                                             input logic sq);
    logic [15:0] amps [5];
    int a, s;
    amps = '{16'h0000, 16'h0400, 16'h1000, 16'h2000, 16'h4000};
    if (f <= 26'd1) return 16'h0000;
    a = int'(amps[(v > 3'd4) ? 4 : int'(v)]);
    s = sq ? a : -a;
    return s[15:0];
  endfunction

  assign m_sl = mdl_sample(freqL, volume, m_sq_l);
  assign m_sr = mdl_sample(freqR, volume, m_sq_r);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t <= 0; m_el_l <= 0; m_el_r <= 0; m_sq_l <= 1'b0; m_sq_r <= 1'b0;
      m_rprev <= 1'b0; m_stb <= 1'b0; m_frame <= 32'd0;
    end else begin
      m_t <= m_t + 1;
      m_stb <= (m_t % 512 == 511);
      if (m_t % 512 == 511) begin
        m_frame <= {m_rprev, m_sl, m_sr[15:1]};
        m_rprev <= m_sr[0];
      end
      if (freqL <= 26'd1) begin m_el_l <= 0; m_sq_l <= 1'b0; end
      else if (m_el_l + 1 >= int'(freqL)) begin m_el_l <= 0; m_sq_l <= ~m_sq_l; end
      else m_el_l <= m_el_l + 1;
      if (freqR <= 26'd1) begin m_el_r <= 0; m_sq_r <= 1'b0; end
      else if (m_el_r + 1 >= int'(freqR)) begin m_el_r <= 0; m_sq_r <= ~m_sq_r; end
      else m_el_r <= m_el_r + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int c;
    c = m_t % 512;
    chk("mclk", audio_mclk, 32'((c / 2) % 2));
    chk("sck",  audio_sck,  32'((c / 8) % 2));
    chk("lrck", audio_lrck, 32'(c / 256));
    chk("stb",  frame_stb,  m_stb);
    chk("sdin", audio_sdin, m_frame[31 - c / 16]);
  end

  task automatic edge3();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset(input logic [25:0] fl, input logic [25:0] fr, input logic [2:0] v);
    edge3();
    rst = 1'b0; freqL = fl; freqR = fr; volume = v;
    edge3();
    edge3();
    rst = 1'b1;
  endtask

  task automatic capture_frame(output logic [31:0] w, output logic ok);
    int n;
    n = 0; ok = 1'b0; w = 32'd0;
    while (n < 1200 && !ok) begin
      @(negedge clk);
      if (frame_stb) ok = 1'b1;
      n++;
    end
    if (ok) begin
      for (int i = 0; i < 32; i++) begin
        if (i > 0) repeat (16) @(negedge clk);
        w[31 - i] = audio_sdin;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  vol;
    logic [25:0] fl;
    logic [25:0] fr;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  localparam logic [25:0] BIG = 26'h3FFFFFF;

  initial begin
    vec_t        vecs [8];
    logic [31:0] w;
    logic        ok;
    int          n, stbs;

    vecs[0] = '{3'd0, BIG,   BIG,   16'h0000, 16'h0000};
    vecs[1] = '{3'd1, BIG,   BIG,   16'hFC00, 16'hFC00};
    vecs[2] = '{3'd2, BIG,   BIG,   16'hF000, 16'hF000};
    vecs[3] = '{3'd3, BIG,   BIG,   16'hE000, 16'hE000};
    vecs[4] = '{3'd4, BIG,   BIG,   16'hC000, 16'hC000};
    vecs[5] = '{3'd6, BIG,   26'd1, 16'hC000, 16'h0000};
    vecs[6] = '{3'd7, BIG,   26'd2, 16'hC000, 16'h4000};
    vecs[7] = '{3'd1, 26'd3, 26'd0, 16'hFC00, 16'h0000};

    // Silent channels: only clocks and periodic strobes.
    do_reset(26'd1, 26'd1, 3'd4);
    stbs = 0;
    for (int i = 0; i < 1100; i++) begin
      edge3();
      if (frame_stb) stbs++;
    end
    chk("silent_stb_count", stbs, 2);

    // First frame after reset for each table entry.
    for (int k = 0; k < 8; k++) begin
      do_reset(vecs[k].fl, vecs[k].fr, vecs[k].vol);
      capture_frame(w, ok);
      chk($sformatf("vec%0d_stb_seen", k), ok, 1);
      chk($sformatf("vec%0d_frame", k), w, {1'b0, vecs[k].exp_l, vecs[k].exp_r[15:1]});
    end

    // Left tone toggling across frames, then a mid-period shortening of the right one.
    do_reset(26'd2500, 26'd5000, 3'd4);
    n = 0;
    while (n < 8000 && m_el_r != 3000) begin edge3(); n++; end
    chk("reach_r_count", 32'(m_el_r), 32'd3000);
    freqR = 26'd100;
    repeat (3000) edge3();

    // Volume 0 with active tones must go quiet from the next frame.
    volume = 3'd0;
    repeat (600) edge3();
    capture_frame(w, ok);
    chk("mute_frame", w, 32'd0);

    // Randomized segments with mid-run changes and occasional resets.
    for (int s = 0; s < 24; s++) begin
      logic [25:0] f [2];
      for (int ch = 0; ch < 2; ch++) begin
        case ($urandom_range(0, 3))
          0:       f[ch] = 26'($urandom_range(0, 1));
          1:       f[ch] = 26'($urandom_range(2, 40));
          2:       f[ch] = 26'($urandom_range(40, 2000));
          default: f[ch] = 26'($urandom);
        endcase
      end
      if ($urandom_range(0, 5) == 0) do_reset(f[0], f[1], 3'($urandom_range(0, 7)));
      else begin freqL = f[0]; freqR = f[1]; volume = 3'($urandom_range(0, 7)); end
      repeat ($urandom_range(300, 1200)) edge3();
      if ($urandom_range(0, 1) == 1) freqL = 26'($urandom_range(0, 300));
      else freqR = 26'($urandom_range(0, 300));
      repeat ($urandom_range(300, 1200)) edge3();
    end

    // Reset mid-frame: outputs clear at once, first strobe 512 clks after release.
    freqL = 26'd300; freqR = 26'd700; volume = 3'd3;
    n = 0;
    while (n < 1200 && (m_t % 512) != 300) begin edge3(); n++; end
    chk("reach_cnt300", 32'(m_t % 512), 32'd300);
    rst = 1'b0;
    #1;
    chk("rst_mclk", audio_mclk, 0);
    chk("rst_sck",  audio_sck,  0);
    chk("rst_lrck", audio_lrck, 0);
    chk("rst_sdin", audio_sdin, 0);
    chk("rst_stb",  frame_stb,  0);
    edge3();
    rst = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (frame_stb) break;
    end
    chk("first_stb_after_rst", n, 512);
    repeat (40) edge3();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_i2s_out.md
AUDIO_I2S_OUT -- requirements
Module: audio_i2s_out

Interface
REQ-001 Parameter SILENT_DIV, default 1: divider values less than or equal to this denote silence.
REQ-002 clk  input  1  system clock, 100 MHz.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 freqL  input  26  left-channel square-wave half-period, in clk cycles.
REQ-005 freqR  input  26  right-channel square-wave half-period, in clk cycles.
REQ-006 volume  input  3  amplitude select; 0 = mute, 1..4 = increasing level, 5..7 treated as 4.
REQ-007 audio_mclk  output  1  master clock, clk/4.
REQ-008 audio_lrck  output  1  word select, clk/512; 0 = left, 1 = right.
REQ-009 audio_sck  output  1  serial bit clock, clk/16.
REQ-010 audio_sdin  output  1  serial data, I2S format, MSB first.
REQ-011 frame_stb  output  1  one-cycle pulse on each frame load.

Function
REQ-012 A free-running 9-bit counter cnt SHALL increment every clk and wrap from 511 to 0.
REQ-013 The clock outputs SHALL be audio_mclk = cnt[1], audio_sck = cnt[3] and audio_lrck = cnt[8], each taken directly from a register bit.
REQ-014 Each channel SHALL own a 26-bit period counter and a square bit.
- When freq > SILENT_DIV: the counter increments each clk.
- On the cycle where the counter is >= freq-1, the counter clears to 0 and the square bit toggles.
REQ-015 A freq change mid-period SHALL take effect immediately.
- If the counter is already >= new freq-1, the channel wraps and toggles on the next clk.
REQ-016 When freq <= SILENT_DIV, the channel counter and square bit SHALL be held at 0 and the channel sample SHALL be 16'h0000.
REQ-017 Amplitude SHALL be selected by volume as follows: 0 -> 16'h0000, 1 -> 16'h0400, 2 -> 16'h1000, 3 -> 16'h2000, 4..7 -> 16'h4000.
REQ-018 Channel sample SHALL be +amplitude when square = 1 and -amplitude (two's complement) when square = 0, with the silence rule of REQ-016 taking priority.
REQ-019 On the clk edge where cnt goes 511 -> 0, the block SHALL:
- capture both channel samples L and R simultaneously;
- load the 32-bit frame register with {Rprev0, L[15:0], R[15:1]}, where Rprev0 is R[0] retained from the previous frame (1-bit I2S delay);
- store R[0] as the new Rprev0;
- pulse frame_stb high for exactly that one cycle.
REQ-020 audio_sdin SHALL be registered and change only on sck falling edges (clk edges where cnt[3:0] goes 15 -> 0).
- Each such edge presents the next frame-register bit, MSB first.
- Bit 31 is presented at cnt = 0, bit 0 at cnt = 496.
REQ-021 Inputs sampled between frame loads SHALL NOT alter the frame currently being shifted (no tearing).
REQ-022 All arithmetic is unsigned except the sample negation; no input value SHALL produce X or overflow the 26-bit counters.

Reset
REQ-023 While rst = 0, the following SHALL be 0: cnt, both period counters, both square bits, the frame register, Rprev0, frame_stb, and all four audio outputs.
REQ-024 Reset asserted mid-frame SHALL take effect immediately.
- After release, cnt restarts at 0.
- The first frame load occurs 512 clks later.
- audio_sdin stays 0 until that load.

Verification
REQ-025 Reset release, freqL = freqR = 1, volume = 4 -> mclk period 4, sck period 16, lrck period 512; sdin always 0; frame_stb every 512 clks.
REQ-026 freqL = 25000, volume = 4 -> left square toggles every 25000 clks; left sample alternates 16'h4000 and 16'hC000 (-16'h4000) across frames.
REQ-027 Forced L = 16'hA5A5, R = 16'h3C3C at load with Rprev0 = 1 -> sdin sequence from cnt = 0 equals 1, A5A5 bits 15..0, 3C3C bits 15..1; next frame slot 0 = 0.
REQ-028 freqR changed from 50000 to 100 while the right counter is at 30000 -> right square toggles on the next clk, then every 100 clks.
REQ-029 volume = 0 with active freqs -> all 32 sdin bits 0 from the next frame onward; volume = 6 -> amplitude 16'h4000.
REQ-030 rst pulsed low at cnt = 300 -> all outputs 0 asynchronously; first frame_stb exactly 512 clks after release.
